// File: rtl/hit_lane_packer_pkg.sv
// Shared types and sizes for the R17 -> R18 hit lane packer.
// A fragment is a signed position/depth vector plus an unsigned color vector.
package hit_lane_packer_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int LANES  = 4;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } pack_state_e;

    typedef struct packed {
        logic signed [AXIS-1:0][SIGFIG-1:0]   hit;
        logic        [COLORS-1:0][SIGFIG-1:0] color;
    } hit_frag_t;

endpackage

// File: rtl/packer_idle_timer.sv
// Counts hit-free cycles while a partial group is pending and raises a
// one-cycle auto-flush strobe once the idle limit is reached.
module packer_idle_timer #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic fill_i,
    input  logic hit_i,
    input  logic flush_i,
    output logic auto_flush_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] SAT  = '1;

    logic [TO_W-1:0] idle_q;
    logic [TO_W-1:0] idle_d;

    always_comb begin
        auto_flush_o = (TIMEOUT != 0) && fill_i && !hit_i && (idle_q == LAST);
        idle_d       = idle_q;
        // A flush while filling always emits, so it restarts the count too.
        if (!fill_i || hit_i || flush_i || auto_flush_o) begin
            idle_d = '0;
        end else if (idle_q != SAT) begin
            idle_d = idle_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/hit_lane_packer.sv
// Gathers the single-lane R17 hit stream into 4-wide groups and emits each
// group on the R18 lanes for one cycle, oldest hit on lane 1.
module hit_lane_packer
    import hit_lane_packer_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [AXIS-1:0][SIGFIG-1:0]   hit_R17S,
    input  logic        [COLORS-1:0][SIGFIG-1:0] color_R17U,
    input  logic                                hit_valid_R17H,
    input  logic                                flush_R17H,
    output logic signed [AXIS-1:0][SIGFIG-1:0]   hit_R18S_1,
    output logic signed [AXIS-1:0][SIGFIG-1:0]   hit_R18S_2,
    output logic signed [AXIS-1:0][SIGFIG-1:0]   hit_R18S_3,
    output logic signed [AXIS-1:0][SIGFIG-1:0]   hit_R18S_4,
    output logic        [COLORS-1:0][SIGFIG-1:0] color_R18U_1,
    output logic        [COLORS-1:0][SIGFIG-1:0] color_R18U_2,
    output logic        [COLORS-1:0][SIGFIG-1:0] color_R18U_3,
    output logic        [COLORS-1:0][SIGFIG-1:0] color_R18U_4,
    output logic                                hit_valid_R18H_1,
    output logic                                hit_valid_R18H_2,
    output logic                                hit_valid_R18H_3,
    output logic                                hit_valid_R18H_4,
    output logic                                pending_RnnnnH,
    output logic [31:0]                         hits_packed_RnnnnU,
    output logic [31:0]                         groups_emitted_RnnnnU
);

    hit_frag_t        in_frag;
    hit_frag_t        slot_q [LANES];
    hit_frag_t        lane_q [LANES];
    hit_frag_t        lane_d [LANES];
    logic [LANES-1:0] lane_v_q;
    logic [LANES-1:0] lane_v_d;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic [2:0]       total;
    pack_state_e      state;
    logic             emit;
    logic             auto_flush;
    logic             pending_q;
    logic [31:0]      hits_q;
    logic [31:0]      hits_d;
    logic [31:0]      groups_q;
    logic [31:0]      groups_d;

    assign in_frag.hit   = hit_R17S;
    assign in_frag.color = color_R17U;

    packer_idle_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_idle_timer (
        .clk          (clk),
        .rst          (rst),
        .fill_i       (state == FILL),
        .hit_i        (hit_valid_R17H),
        .flush_i      (flush_R17H),
        .auto_flush_o (auto_flush)
    );

    always_comb begin
        state    = (cnt_q == 2'd0) ? EMPTY : FILL;
        total    = {1'b0, cnt_q} + {2'b00, hit_valid_R17H};
        emit     = (hit_valid_R17H && (cnt_q == 2'd3)) ||
                   (flush_R17H && (total != 3'd0)) ||
                   auto_flush;
        cnt_d    = emit ? 2'd0 : total[1:0];
        hits_d   = hits_q;
        groups_d = groups_q;
        lane_v_d = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_d[k] = lane_q[k];
            if (emit) begin
                if (3'(k) < total) begin
                    lane_v_d[k] = 1'b1;
                    // This cycle's hit lands on the lane it would have filled.
                    lane_d[k]   = (hit_valid_R17H && (2'(k) == cnt_q)) ? in_frag : slot_q[k];
                end else begin
                    lane_d[k]   = '0;
                end
            end
        end
        if (emit) begin
            hits_d   = hits_q + 32'(total);
            groups_d = groups_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 2'd0;
            lane_v_q  <= '0;
            pending_q <= 1'b0;
            hits_q    <= '0;
            groups_q  <= '0;
            for (int k = 0; k < LANES; k++) begin
                slot_q[k] <= '0;
                lane_q[k] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            lane_v_q  <= lane_v_d;
            pending_q <= (cnt_d != 2'd0);
            hits_q    <= hits_d;
            groups_q  <= groups_d;
            if (hit_valid_R17H) begin
                slot_q[cnt_q] <= in_frag;
            end
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

    assign hit_R18S_1            = lane_q[0].hit;
    assign hit_R18S_2            = lane_q[1].hit;
    assign hit_R18S_3            = lane_q[2].hit;
    assign hit_R18S_4            = lane_q[3].hit;
    assign color_R18U_1          = lane_q[0].color;
    assign color_R18U_2          = lane_q[1].color;
    assign color_R18U_3          = lane_q[2].color;
    assign color_R18U_4          = lane_q[3].color;
    assign hit_valid_R18H_1      = lane_v_q[0];
    assign hit_valid_R18H_2      = lane_v_q[1];
    assign hit_valid_R18H_3      = lane_v_q[2];
    assign hit_valid_R18H_4      = lane_v_q[3];
    assign pending_RnnnnH        = pending_q;
    assign hits_packed_RnnnnU    = hits_q;
    assign groups_emitted_RnnnnU = groups_q;

endmodule

// File: tb/tb_hit_lane_packer.sv
// Bench for hit_lane_packer: hand-derived vector table, hand-written corner
// sequences, and a queue-based scoreboard fed by a behavioural packing model.
module tb_hit_lane_packer;
  import hit_lane_packer_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;
  localparam int FW      = $bits(hit_frag_t);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [AXIS-1:0][SIGFIG-1:0]   hit_R17S = '0;
  logic        [COLORS-1:0][SIGFIG-1:0] color_R17U = '0;
  logic                                hit_valid_R17H = 1'b0;
  logic                                flush_R17H = 1'b0;
  logic signed [AXIS-1:0][SIGFIG-1:0]   hit_R18S_1, hit_R18S_2, hit_R18S_3, hit_R18S_4;
  logic        [COLORS-1:0][SIGFIG-1:0] color_R18U_1, color_R18U_2, color_R18U_3, color_R18U_4;
  logic                                hit_valid_R18H_1, hit_valid_R18H_2, hit_valid_R18H_3, hit_valid_R18H_4;
  logic                                pending_RnnnnH;
  logic [31:0]                         hits_packed_RnnnnU, groups_emitted_RnnnnU;

  hit_lane_packer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .hit_R17S(hit_R17S), .color_R17U(color_R17U),
    .hit_valid_R17H(hit_valid_R17H), .flush_R17H(flush_R17H),
    .hit_R18S_1(hit_R18S_1), .hit_R18S_2(hit_R18S_2), .hit_R18S_3(hit_R18S_3), .hit_R18S_4(hit_R18S_4),
    .color_R18U_1(color_R18U_1), .color_R18U_2(color_R18U_2),
    .color_R18U_3(color_R18U_3), .color_R18U_4(color_R18U_4),
    .hit_valid_R18H_1(hit_valid_R18H_1), .hit_valid_R18H_2(hit_valid_R18H_2),
    .hit_valid_R18H_3(hit_valid_R18H_3), .hit_valid_R18H_4(hit_valid_R18H_4),
    .pending_RnnnnH(pending_RnnnnH),
    .hits_packed_RnnnnU(hits_packed_RnnnnU),
    .groups_emitted_RnnnnU(groups_emitted_RnnnnU)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0]      v;
    hit_frag_t [3:0] d;
    logic            pend;
    logic [31:0]     hp;
    logic [31:0]     ge;
  } exp_t;

  exp_t            exp_q[$];
  hit_frag_t       m_pend[$];
  hit_frag_t [3:0] m_lane;
  int              m_idle;
  logic [31:0]     m_hp;
  logic [31:0]     m_ge;
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] act_v();
    return {hit_valid_R18H_4, hit_valid_R18H_3, hit_valid_R18H_2, hit_valid_R18H_1};
  endfunction

  function automatic hit_frag_t act_lane(input int k);
    hit_frag_t a;
    case (k)
      0: begin a.hit = hit_R18S_1; a.color = color_R18U_1; end
      1: begin a.hit = hit_R18S_2; a.color = color_R18U_2; end
      2: begin a.hit = hit_R18S_3; a.color = color_R18U_3; end
      default: begin a.hit = hit_R18S_4; a.color = color_R18U_4; end
    endcase
    return a;
  endfunction

  function automatic hit_frag_t mk_frag(input int n);
    hit_frag_t f;
    f.hit[0] = SIGFIG'(n) << RADIX;
    f.hit[1] = SIGFIG'($urandom);
    f.hit[2] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++) f.color[c] = SIGFIG'($urandom);
    return f;
  endfunction

  task automatic sb_check();
    exp_t e;
    e = exp_q.pop_front();
    chk("valid", FW'(act_v()), FW'(e.v));
    chk("pending", FW'(pending_RnnnnH), FW'(e.pend));
    chk("hits_packed", FW'(hits_packed_RnnnnU), FW'(e.hp));
    chk("groups_emitted", FW'(groups_emitted_RnnnnU), FW'(e.ge));
    for (int k = 0; k < 4; k++) chk($sformatf("lane%0d_data", k + 1), act_lane(k), e.d[k]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit hv, input bit fl, input int n);
    hit_frag_t f;
    exp_t      e;
    bit        fill, auto_f, emit;
    int        tot;
    f = mk_frag(n);
    hit_R17S = f.hit; color_R17U = f.color;
    hit_valid_R17H = hv; flush_R17H = fl;
    fill   = (m_pend.size() > 0);
    tot    = m_pend.size() + int'(hv);
    auto_f = fill && !hv && (m_idle == TIMEOUT - 1);
    emit   = (hv && m_pend.size() == 3) || (fl && tot > 0) || auto_f;
    if (!fill || hv || emit) m_idle = 0;
    else if (m_idle < (2 ** TO_W) - 1) m_idle++;
    if (hv) m_pend.push_back(f);
    e = '0;
    if (emit) begin
      for (int k = 0; k < 4; k++) begin
        m_lane[k] = (k < m_pend.size()) ? m_pend[k] : '0;
        e.v[k]    = (k < m_pend.size());
      end
      m_hp = m_hp + 32'(m_pend.size());
      m_ge = m_ge + 32'd1;
      m_pend.delete();
    end
    e.d = m_lane; e.pend = (m_pend.size() > 0); e.hp = m_hp; e.ge = m_ge;
    exp_q.push_back(e);
    @(posedge clk); #1;
    sb_check();
  endtask

  task automatic do_reset();
    exp_t      e;
    hit_frag_t f;
    f = mk_frag(99);
    rst = 1'b1; hit_R17S = f.hit; color_R17U = f.color;
    hit_valid_R17H = 1'b1; flush_R17H = 1'b1;
    m_pend.delete(); m_idle = 0; m_hp = '0; m_ge = '0; m_lane = '0;
    e = '0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    sb_check();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        hv;
    logic        fl;
    logic [7:0]  n;
    logic [3:0]  ev;
    logic [31:0] ehp;
    logic [31:0] ege;
    logic        epend;
    logic [7:0]  ex1;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'd1, 4'b0000, 32'd0, 32'd0, 1'b1, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 8'd2, 4'b0000, 32'd0, 32'd0, 1'b1, 8'd0};
    tbl[2] = '{1'b1, 1'b0, 8'd3, 4'b0000, 32'd0, 32'd0, 1'b1, 8'd0};
    tbl[3] = '{1'b1, 1'b0, 8'd4, 4'b1111, 32'd4, 32'd1, 1'b0, 8'd1};
    tbl[4] = '{1'b1, 1'b0, 8'd5, 4'b0000, 32'd4, 32'd1, 1'b1, 8'd0};
    tbl[5] = '{1'b1, 1'b0, 8'd6, 4'b0000, 32'd4, 32'd1, 1'b1, 8'd0};
    tbl[6] = '{1'b1, 1'b1, 8'd7, 4'b0111, 32'd7, 32'd2, 1'b0, 8'd5};
    tbl[7] = '{1'b0, 1'b1, 8'd0, 4'b0000, 32'd7, 32'd2, 1'b0, 8'd0};
    tbl[8] = '{1'b0, 1'b0, 8'd0, 4'b0000, 32'd7, 32'd2, 1'b0, 8'd0};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].hv, tbl[i].fl, int'(tbl[i].n));
      chk($sformatf("tbl%0d_valid", i), FW'(act_v()), FW'(tbl[i].ev));
      chk($sformatf("tbl%0d_hp", i), FW'(hits_packed_RnnnnU), FW'(tbl[i].ehp));
      chk($sformatf("tbl%0d_ge", i), FW'(groups_emitted_RnnnnU), FW'(tbl[i].ege));
      chk($sformatf("tbl%0d_pend", i), FW'(pending_RnnnnH), FW'(tbl[i].epend));
      if (tbl[i].ev != 4'b0000)
        chk($sformatf("tbl%0d_x1", i), FW'(hit_R18S_1[0]), FW'(SIGFIG'(tbl[i].ex1) << RADIX));
    end

    // Twelve back-to-back hits: three full groups, lane k carries n=4g+k.
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 1'b0, i);
      if (i % 4 == 0)
        chk("b2b_x4", FW'(hit_R18S_4[0]), FW'(SIGFIG'(i) << RADIX));
    end
    chk("b2b_ge", FW'(groups_emitted_RnnnnU), FW'(32'd5));
    chk("b2b_hp", FW'(hits_packed_RnnnnU), FW'(32'd19));

    // Idle timeout: single hit at t, emission observed after edge t+17.
    drive(1'b1, 1'b0, 1);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 0);
      if (i == 15) chk("to1_early", FW'(act_v()), FW'(4'b0000));
    end
    chk("to1_single", FW'(act_v()), FW'(4'b0001));
    // A hit at t+10 restarts the count: two-lane emission after edge t+27.
    drive(1'b1, 1'b0, 2);
    for (int i = 1; i <= 9; i++) drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 3);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 0);
      if (i == 15) chk("to2_early", FW'(act_v()), FW'(4'b0000));
    end
    chk("to2_double", FW'(act_v()), FW'(4'b0011));
    chk("to2_x2", FW'(hit_R18S_2[0]), FW'(SIGFIG'(3) << RADIX));

    // Reset mid-gather drops pending hits.
    for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, i);
    do_reset();
    drive(1'b1, 1'b1, 9);
    chk("rst_valid", FW'(act_v()), FW'(4'b0001));
    chk("rst_x1", FW'(hit_R18S_1[0]), FW'(SIGFIG'(9) << RADIX));
    chk("rst_hp", FW'(hits_packed_RnnnnU), FW'(32'd1));
    chk("rst_ge", FW'(groups_emitted_RnnnnU), FW'(32'd1));

    // Hit + flush with three pending: exactly one full emission.
    for (int i = 1; i <= 3; i++) drive(1'b1, 1'b0, i);
    drive(1'b1, 1'b1, 4);
    chk("hf_valid", FW'(act_v()), FW'(4'b1111));
    chk("hf_ge", FW'(groups_emitted_RnnnnU), FW'(32'd2));
    drive(1'b0, 1'b1, 0);
    chk("noop_valid", FW'(act_v()), FW'(4'b0000));
    chk("noop_ge", FW'(groups_emitted_RnnnnU), FW'(32'd2));
    chk("noop_hp", FW'(hits_packed_RnnnnU), FW'(32'd5));

    // Random traffic: dense then sparse so timeouts also fire.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < ((i < 200) ? 70 : 8),
            $urandom_range(0, 19) == 0, 100 + i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
